// File: rtl/counter.sv
// counter: WIDTH-bit up/down counter with enable, synchronous load (clamped
// to MAX), wrap or saturate at the terminals, and a combinational
// terminal-count flag. Also drives an active-high LED from an active-low key.
//
// Optional build macro: COUNTER_KEY_SYNC_EN
//   defined   - key passes through a two-flop synchronizer (flops reset to
//               "released"), so led follows key two clocks later.
//   undefined - led = ~key, purely combinational.
module counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             key,
    output logic [WIDTH-1:0] cnt_value,
    output logic             tc,
    output logic             led
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_value == MAX_V);
    assign at_zero = (cnt_value == '0);

    // Terminal count: high in the cycle whose edge wraps (or would wrap).
    // Gated by rst because the held-at-zero count would otherwise flag
    // a down-count terminal during reset.
    assign tc = ~rst & en & ~load & ((up & at_max) | (~up & at_zero));

    // Next-count selection: load beats enable; terminals wrap or hold.
    always_comb begin
        cnt_next = cnt_value;
        if (load) begin
            cnt_next = (load_value > MAX_V) ? MAX_V : load_value;
        end else if (en && up) begin
            if (at_max)
                cnt_next = (SATURATE != 0) ? MAX_V : '0;
            else
                cnt_next = cnt_value + 1'b1;
        end else if (en) begin
            if (at_zero)
                cnt_next = (SATURATE != 0) ? '0 : MAX_V;
            else
                cnt_next = cnt_value - 1'b1;
        end
    end

    // Count register, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_value <= '0;
        else
            cnt_value <= cnt_next;
    end

`ifdef COUNTER_KEY_SYNC_EN
    logic key_sync1;
    logic key_sync2;

    // Two-flop key synchronizer; resets to "released" so the LED stays dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sync1 <= 1'b1;
            key_sync2 <= 1'b1;
        end else begin
            key_sync1 <= key;
            key_sync2 <= key_sync1;
        end
    end

    assign led = ~key_sync2;
`else
    assign led = ~key;
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized check of two counter instances (wrap MAX=15 and
// saturate MAX=10) against a plain-arithmetic reference model.
module tb_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, up, load, key;
    logic [W-1:0] lv;
    logic [W-1:0] cnt_w, cnt_s;
    logic         tc_w, tc_s, led_w, led_s;

    int errors = 0;
    int checks = 0;
    int m_w = 0;
    int m_s = 0;
    int k1 = 1;
    int k2 = 1;

    always #5 clk = ~clk;

    counter #(.WIDTH(W), .MAX(15), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_value(lv), .key(key), .cnt_value(cnt_w), .tc(tc_w), .led(led_w)
    );

    counter #(.WIDTH(W), .MAX(10), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_value(lv), .key(key), .cnt_value(cnt_s), .tc(tc_s), .led(led_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next count from the rules: modulo MAX+1 when wrapping, clipped when saturating.
    function automatic int model_next(int c, int mx, bit sat);
        int v;
        if (load) return (int'(lv) > mx) ? mx : int'(lv);
        if (!en) return c;
        if (sat) begin
            v = up ? c + 1 : c - 1;
            if (v > mx) v = mx;
            if (v < 0) v = 0;
            return v;
        end
        return up ? (c + 1) % (mx + 1) : (c + mx) % (mx + 1);
    endfunction

    function automatic bit model_tc(int c, int mx);
        return !rst && en && !load && ((up && c == mx) || (!up && c == 0));
    endfunction

    function automatic bit model_led();
`ifdef COUNTER_KEY_SYNC_EN
        return k2 == 0;
`else
        return !key;
`endif
    endfunction

    // One clock: check combinational outputs, take the edge, check the count.
    task automatic step();
        #1;
        check("tc_wrap", tc_w, model_tc(m_w, 15));
        check("tc_sat", tc_s, model_tc(m_s, 10));
        check("led_pre", led_w, model_led());
        @(posedge clk);
        if (rst) begin
            m_w = 0; m_s = 0; k1 = 1; k2 = 1;
        end else begin
            m_w = model_next(m_w, 15, 1'b0);
            m_s = model_next(m_s, 10, 1'b1);
            k2 = k1; k1 = key;
        end
        #1;
        check("cnt_wrap", cnt_w, m_w);
        check("cnt_sat", cnt_s, m_s);
        check("led_post", led_s, model_led());
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; lv = '0; key = 1'b1;
        @(posedge clk);
        #1;
        // reset held two cycles with en=1
        step(); step();
        check("rst_cnt", cnt_w, 0);

        // free-running up count
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("wrap_end", cnt_w, 4);

        // mid-count async reset at 7
        load = 1'b1; lv = '0; step();
        load = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("pre_rst7", cnt_w, 7);
        #2 rst = 1'b1;
        #1;
        m_w = 0; m_s = 0; k1 = 1; k2 = 1;
        check("async_rst_w", cnt_w, 0);
        check("async_rst_s", cnt_s, 0);
        step();
        rst = 1'b0;

        // down from 2 into the zero terminal
        load = 1'b1; lv = 4'd2; step();
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("sat_floor", cnt_s, 0);

        // load priority over enable, and clamp to MAX
        load = 1'b1; lv = 4'd5; step();
        lv = 4'd9; up = 1'b1; en = 1'b1; step();
        check("load9", cnt_w, 9);
        lv = 4'd15; step();
        check("clamp10", cnt_s, 10);

        // enable off holds
        lv = 4'd3; step();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("hold3", cnt_w, 3);

        // LED press / release
        key = 1'b1; step(); step();
        key = 1'b0; step(); step();
        key = 1'b1; step(); step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(49) == 0);
            load = ($urandom_range(5) == 0);
            en   = ($urandom_range(3) != 0);
            up   = $urandom_range(1);
            lv   = W'($urandom_range(15));
            if ($urandom_range(2) == 0) key = ~key;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
